pause_flow_ctrl: RTL and testbench
==================================

Name: pause_flow_ctrl

Overview:
- Watermark-driven 802.3x flow-control scheduler for the MAC TX pause interface.
- Monitors the RX FIFO fill level and the FIFO full flag, and issues XOFF pause requests with a fixed quanta.
- Refreshes the XOFF before the pause expires while the FIFO stays congested.
- Issues an explicit XON (quanta 0) once the FIFO drains below a low watermark.
- Sits between the RX FIFO and the MAC pause-frame generator; uses a req/ack handshake in the tx_clk domain.

Parameters:
FILL_W, 11, width of fifo_level.
XOFF_THRESH, 768, fill level at or above which XOFF is requested.
XON_THRESH, 256, fill level at or below which XON is requested; must be < XOFF_THRESH.
PAUSE_QUANTA, 16'h5a0f, tx_pause_val sent in XOFF frames.
REFRESH_CYCLES, 1000000, cycles in PAUSED before XOFF is re-sent; must be ≥ 2.
SRC_ADDR, 48'h0180C2000001, address driven on tx_pause_source_addr during a request.

Ports:
tx_clk  in  1  sole clock.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  flow control enabled.
fifo_level  in  FILL_W  current RX FIFO occupancy.
is_fifo_full  in  1  FIFO full flag; forces the congested condition.
tx_pause_ack  in  1  one-cycle pulse from the MAC: pause frame accepted.
tx_pause_req  out  1  pause frame request, level.
tx_pause_val  out  16  quanta for the requested frame.
tx_pause_source_addr  out  48  address for the requested frame.
paused  out  1  high while the link partner is believed paused.
xoff_cnt  out  16  accepted XOFF frames, saturating.
xon_cnt  out  16  accepted XON frames, saturating.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE.
  - All outputs 0; refresh counter 0.
- Conditions:
  - hi = is_fifo_full | (fifo_level >= XOFF_THRESH).
  - lo = !is_fifo_full & (fifo_level <= XON_THRESH).
- States (all outputs registered):
  - IDLE: if enable & hi, go to XOFF_REQ. tx_pause_req=1, val=PAUSE_QUANTA, addr=SRC_ADDR on the next cycle.
  - XOFF_REQ: hold req/val/addr stable until tx_pause_ack. On ack:
    - Go to PAUSED; req, val and addr go to 0 the next cycle.
    - Set paused=1.
    - Load the refresh counter with REFRESH_CYCLES-1.
    - Increment xoff_cnt.
  - PAUSED, checked in this priority order:
    1. !enable or lo: go to XON_REQ (req=1, val=0, addr=SRC_ADDR).
    2. Refresh counter == 0: go to XOFF_REQ.
    3. Otherwise decrement the counter.
  - XON_REQ: hold until ack. On ack:
    - Go to IDLE; set paused=0.
    - Increment xon_cnt.
- Handshake rules:
  - A request is never retracted or changed once raised. A level change during XOFF_REQ or XON_REQ is only acted on after the ack.
  - tx_pause_ack is ignored when tx_pause_req=0.
  - After every ack, req is low for at least one cycle; the next request may start the cycle after that.
  - Ack in the same cycle that req first rises counts as valid.
- Hysteresis: no new XOFF/XON is scheduled while XON_THRESH < level < XOFF_THRESH, except the refresh in PAUSED.
- enable=0:
  - No new XOFF from IDLE.
  - An in-flight XOFF completes, then PAUSED immediately goes to XON_REQ.
- Refresh period: exactly REFRESH_CYCLES cycles from the XOFF ack to the next tx_pause_req rise, if congestion persists.
- Counters saturate at 16'hFFFF; no wrap.
- tx_pause_source_addr and tx_pause_val are 0 whenever tx_pause_req=0.
- Reset mid-request: req drops asynchronously, no ack is expected afterwards, and counters clear.

Test Plan:
Bench parameters: FILL_W=5, XOFF_THRESH=24, XON_THRESH=8, REFRESH_CYCLES=20.
1. enable=1; fifo_level ramps 0→24; ack 3 cycles after req → req rises one cycle after level=24 with val=16'h5a0f and addr=48'h0180C2000001; paused=1 and xoff_cnt=1 after the ack; req low the cycle after the ack.
2. Level held at 30 after the XOFF ack → req rises again exactly 20 cycles after the ack with val=16'h5a0f; xoff_cnt=2 after its ack.
3. Paused, then level drops to 8 → XON request with val=0; after the ack paused=0, xon_cnt=1, state IDLE; level at 15 afterwards produces no request.
4. Level 24 then drops to 0 before the ack (delayed 10 cycles) → XOFF held unchanged until the ack, then XON issued the cycle after req falls.
5. is_fifo_full=1 with level=5 → XOFF requested. With enable=0 in IDLE and level=31 → no request.
6. rst_n asserted low while req=1 → req, val, addr, paused and counters are 0 immediately, with no clock edge needed. Ack pulses with req=0 leave the counters unchanged.

Source files
------------

// File: rtl/pause_flow_ctrl_if.sv
// Pause-frame request/ack channel between the flow-control scheduler and the MAC TX.
// Widths are fixed by the MAC pause-frame format (16-bit quanta, 48-bit address).
interface pause_flow_ctrl_if;
    logic        tx_pause_req;
    logic [15:0] tx_pause_val;
    logic [47:0] tx_pause_source_addr;
    logic        tx_pause_ack;

    modport master (
        output tx_pause_req,
        output tx_pause_val,
        output tx_pause_source_addr,
        input  tx_pause_ack
    );

    modport slave (
        input  tx_pause_req,
        input  tx_pause_val,
        input  tx_pause_source_addr,
        output tx_pause_ack
    );
endinterface

// File: rtl/pause_flow_ctrl.sv
// Watermark-driven 802.3x pause scheduler: XOFF on congestion, periodic XOFF refresh,
// explicit XON once the RX FIFO drains. All outputs registered; req/ack in tx_clk domain.
module pause_flow_ctrl #(
    parameter int unsigned FILL_W         = 11,
    parameter int unsigned XOFF_THRESH    = 768,
    parameter int unsigned XON_THRESH     = 256,
    parameter logic [15:0] PAUSE_QUANTA   = 16'h5a0f,
    parameter int unsigned REFRESH_CYCLES = 1000000,
    parameter logic [47:0] SRC_ADDR       = 48'h0180C2000001
) (
    input  logic                  tx_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [FILL_W-1:0]     fifo_level,
    input  logic                  is_fifo_full,
    pause_flow_ctrl_if.master     pause,
    output logic                  paused,
    output logic [15:0]           xoff_cnt,
    output logic [15:0]           xon_cnt
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  REFRESH_LOAD = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [FILL_W-1:0] XOFF_LVL     = FILL_W'(XOFF_THRESH);
    localparam logic [FILL_W-1:0] XON_LVL      = FILL_W'(XON_THRESH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XOFF_REQ = 2'd1,
        PAUSED   = 2'd2,
        XON_REQ  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [15:0]       val_q, val_d;
    logic [47:0]       addr_q, addr_d;
    logic              paused_q, paused_d;
    logic [CNT_W-1:0]  refresh_q, refresh_d;
    logic [15:0]       xoff_q, xoff_d;
    logic [15:0]       xon_q, xon_d;

    logic hi_c;
    logic lo_c;
    logic ack_c;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Watermark conditions; a full flag overrides the level in both directions.
    assign hi_c  = is_fifo_full | (fifo_level >= XOFF_LVL);
    assign lo_c  = ~is_fifo_full & (fifo_level <= XON_LVL);
    assign ack_c = pause.tx_pause_ack & req_q;

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            val_q     <= '0;
            addr_q    <= '0;
            paused_q  <= 1'b0;
            refresh_q <= '0;
            xoff_q    <= '0;
            xon_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            val_q     <= val_d;
            addr_q    <= addr_d;
            paused_q  <= paused_d;
            refresh_q <= refresh_d;
            xoff_q    <= xoff_d;
            xon_q     <= xon_d;
        end
    end

    // Next-state and registered-output logic; requests are only changed on ack.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        val_d     = val_q;
        addr_d    = addr_q;
        paused_d  = paused_q;
        refresh_d = refresh_q;
        xoff_d    = xoff_q;
        xon_d     = xon_q;

        unique case (state_q)
            IDLE: begin
                if (enable && hi_c) begin
                    state_d = XOFF_REQ;
                    req_d   = 1'b1;
                    val_d   = PAUSE_QUANTA;
                    addr_d  = SRC_ADDR;
                end
            end
            XOFF_REQ: begin
                if (ack_c) begin
                    state_d   = PAUSED;
                    req_d     = 1'b0;
                    val_d     = '0;
                    addr_d    = '0;
                    paused_d  = 1'b1;
                    refresh_d = REFRESH_LOAD;
                    xoff_d    = sat_inc(xoff_q);
                end
            end
            PAUSED: begin
                if (!enable || lo_c) begin
                    state_d = XON_REQ;
                    req_d   = 1'b1;
                    val_d   = '0;
                    addr_d  = SRC_ADDR;
                end else if (refresh_q == '0) begin
                    state_d = XOFF_REQ;
                    req_d   = 1'b1;
                    val_d   = PAUSE_QUANTA;
                    addr_d  = SRC_ADDR;
                end else begin
                    refresh_d = refresh_q - CNT_W'(1);
                end
            end
            XON_REQ: begin
                if (ack_c) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    val_d    = '0;
                    addr_d   = '0;
                    paused_d = 1'b0;
                    xon_d    = sat_inc(xon_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pause.tx_pause_req         = req_q;
    assign pause.tx_pause_val         = val_q;
    assign pause.tx_pause_source_addr = addr_q;
    assign paused                     = paused_q;
    assign xoff_cnt                   = xoff_q;
    assign xon_cnt                    = xon_q;

    // Handshake invariants: a raised request holds until acked, then drops for a cycle.
    a_req_hold: assert property (@(posedge tx_clk) disable iff (!rst_n)
        (req_q && !pause.tx_pause_ack) |=> (req_q && $stable(val_q) && $stable(addr_q)));
    a_req_gap: assert property (@(posedge tx_clk) disable iff (!rst_n)
        (req_q && pause.tx_pause_ack) |=> !req_q);
    a_idle_zero: assert property (@(posedge tx_clk) disable iff (!rst_n)
        !req_q |-> (val_q == '0 && addr_q == '0));

endmodule

// File: tb/tb_pause_flow_ctrl.sv
// Directed bench for pause_flow_ctrl: XOFF, refresh, XON, hysteresis, enable and async reset.
module tb_pause_flow_ctrl;

    localparam int unsigned FILL_W  = 5;
    localparam int unsigned REFRESH = 20;
    localparam logic [15:0] QUANTA  = 16'h5a0f;
    localparam logic [47:0] SRC     = 48'h0180C2000001;

    logic              tx_clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [FILL_W-1:0] fifo_level;
    logic              is_fifo_full;
    logic              paused;
    logic [15:0]       xoff_cnt;
    logic [15:0]       xon_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pause_flow_ctrl_if pif();

    pause_flow_ctrl #(
        .FILL_W        (FILL_W),
        .XOFF_THRESH   (24),
        .XON_THRESH    (8),
        .PAUSE_QUANTA  (QUANTA),
        .REFRESH_CYCLES(REFRESH),
        .SRC_ADDR      (SRC)
    ) dut (
        .tx_clk      (tx_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .fifo_level  (fifo_level),
        .is_fifo_full(is_fifo_full),
        .pause       (pif.master),
        .paused      (paused),
        .xoff_cnt    (xoff_cnt),
        .xon_cnt     (xon_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic ack_pulse();
        pif.tx_pause_ack = 1'b1;
        tick();
        pif.tx_pause_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; fifo_level = '0; is_fifo_full = 1'b0;
        pif.tx_pause_ack = 1'b0;
        tick(); tick();
        n_checks++;
        if (pif.tx_pause_req !== 1'b0 || pif.tx_pause_val !== 16'h0 || pif.tx_pause_source_addr !== 48'h0
            || paused !== 1'b0 || xoff_cnt !== 16'h0 || xon_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b val=%h addr=%h paused=%b xoff=%0d xon=%0d, required all 0",
                     pif.tx_pause_req, pif.tx_pause_val, pif.tx_pause_source_addr, paused, xoff_cnt, xon_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_xoff_ramp();
        enable = 1'b1;
        for (int lvl = 0; lvl < 24; lvl += 4) begin
            fifo_level = FILL_W'(lvl);
            tick();
            n_checks++;
            if (pif.tx_pause_req !== 1'b0) begin
                n_fail++;
                $display("FAIL ramp_no_req lvl=%0d: req=%b, required 0", lvl, pif.tx_pause_req);
            end
        end
        fifo_level = 5'd24;
        tick();
        n_checks++;
        if (pif.tx_pause_req !== 1'b1 || pif.tx_pause_val !== QUANTA || pif.tx_pause_source_addr !== SRC) begin
            n_fail++;
            $display("FAIL xoff_raise: req=%b val=%h addr=%h, required 1 %h %h",
                     pif.tx_pause_req, pif.tx_pause_val, pif.tx_pause_source_addr, QUANTA, SRC);
        end
        tick(); tick();
        n_checks++;
        if (pif.tx_pause_req !== 1'b1 || pif.tx_pause_val !== QUANTA || paused !== 1'b0) begin
            n_fail++;
            $display("FAIL xoff_hold: req=%b val=%h paused=%b, required 1 %h 0",
                     pif.tx_pause_req, pif.tx_pause_val, paused, QUANTA);
        end
        ack_pulse();
        n_checks++;
        if (pif.tx_pause_req !== 1'b0 || paused !== 1'b1 || xoff_cnt !== 16'd1
            || pif.tx_pause_val !== 16'h0 || pif.tx_pause_source_addr !== 48'h0) begin
            n_fail++;
            $display("FAIL xoff_ack: req=%b paused=%b xoff=%0d val=%h addr=%h, required 0 1 1 0 0",
                     pif.tx_pause_req, paused, xoff_cnt, pif.tx_pause_val, pif.tx_pause_source_addr);
        end
    endtask

    // Called right after an XOFF ack; the refresh request must rise on the REFRESH-th edge.
    task automatic test_refresh(input logic [15:0] exp_cnt);
        fifo_level = 5'd30;
        for (int i = 1; i < REFRESH; i++) begin
            tick();
            n_checks++;
            if (pif.tx_pause_req !== 1'b0) begin
                n_fail++;
                $display("FAIL refresh_early cycle=%0d: req=%b, required 0", i, pif.tx_pause_req);
            end
        end
        tick();
        n_checks++;
        if (pif.tx_pause_req !== 1'b1 || pif.tx_pause_val !== QUANTA) begin
            n_fail++;
            $display("FAIL refresh_raise: req=%b val=%h, required 1 %h", pif.tx_pause_req, pif.tx_pause_val, QUANTA);
        end
        ack_pulse();
        n_checks++;
        if (xoff_cnt !== exp_cnt || paused !== 1'b1 || pif.tx_pause_req !== 1'b0) begin
            n_fail++;
            $display("FAIL refresh_ack: xoff=%0d paused=%b req=%b, required %0d 1 0",
                     xoff_cnt, paused, pif.tx_pause_req, exp_cnt);
        end
    endtask

    task automatic test_xon();
        fifo_level = 5'd8;
        tick();
        n_checks++;
        if (pif.tx_pause_req !== 1'b1 || pif.tx_pause_val !== 16'h0 || pif.tx_pause_source_addr !== SRC) begin
            n_fail++;
            $display("FAIL xon_raise: req=%b val=%h addr=%h, required 1 0 %h",
                     pif.tx_pause_req, pif.tx_pause_val, pif.tx_pause_source_addr, SRC);
        end
        ack_pulse();
        n_checks++;
        if (paused !== 1'b0 || xon_cnt !== 16'd1 || pif.tx_pause_req !== 1'b0) begin
            n_fail++;
            $display("FAIL xon_ack: paused=%b xon=%0d req=%b, required 0 1 0", paused, xon_cnt, pif.tx_pause_req);
        end
        fifo_level = 5'd15;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (pif.tx_pause_req !== 1'b0) begin
                n_fail++;
                $display("FAIL hysteresis cycle=%0d: req=%b, required 0", i, pif.tx_pause_req);
            end
        end
    endtask

    task automatic test_drain_before_ack();
        fifo_level = 5'd24;
        tick();
        fifo_level = 5'd0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (pif.tx_pause_req !== 1'b1 || pif.tx_pause_val !== QUANTA) begin
                n_fail++;
                $display("FAIL xoff_stable cycle=%0d: req=%b val=%h, required 1 %h",
                         i, pif.tx_pause_req, pif.tx_pause_val, QUANTA);
            end
            if (i < 9) tick();
        end
        ack_pulse();
        n_checks++;
        if (pif.tx_pause_req !== 1'b0 || paused !== 1'b1 || xoff_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL drain_ack: req=%b paused=%b xoff=%0d, required 0 1 3", pif.tx_pause_req, paused, xoff_cnt);
        end
        tick();
        n_checks++;
        if (pif.tx_pause_req !== 1'b1 || pif.tx_pause_val !== 16'h0) begin
            n_fail++;
            $display("FAIL drain_xon: req=%b val=%h, required 1 0", pif.tx_pause_req, pif.tx_pause_val);
        end
        ack_pulse();
        n_checks++;
        if (paused !== 1'b0 || xon_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL drain_xon_ack: paused=%b xon=%0d, required 0 2", paused, xon_cnt);
        end
    endtask

    task automatic test_full_and_enable();
        fifo_level = 5'd5; is_fifo_full = 1'b1;
        tick();
        n_checks++;
        if (pif.tx_pause_req !== 1'b1 || pif.tx_pause_val !== QUANTA) begin
            n_fail++;
            $display("FAIL full_xoff: req=%b val=%h, required 1 %h", pif.tx_pause_req, pif.tx_pause_val, QUANTA);
        end
        ack_pulse();
        enable = 1'b0;
        tick();
        n_checks++;
        if (pif.tx_pause_req !== 1'b1 || pif.tx_pause_val !== 16'h0 || xoff_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL disable_xon: req=%b val=%h xoff=%0d, required 1 0 4",
                     pif.tx_pause_req, pif.tx_pause_val, xoff_cnt);
        end
        ack_pulse();
        is_fifo_full = 1'b0; fifo_level = 5'd31;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (pif.tx_pause_req !== 1'b0 || paused !== 1'b0 || xon_cnt !== 16'd3) begin
                n_fail++;
                $display("FAIL disabled_idle cycle=%0d: req=%b paused=%b xon=%0d, required 0 0 3",
                         i, pif.tx_pause_req, paused, xon_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_request();
        enable = 1'b1;
        tick();
        ack_pulse();
        test_refresh(16'd6);
        for (int i = 1; i < REFRESH; i++) tick();
        tick();
        n_checks++;
        if (pif.tx_pause_req !== 1'b1 || paused !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: req=%b paused=%b, required 1 1", pif.tx_pause_req, paused);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (pif.tx_pause_req !== 1'b0 || pif.tx_pause_val !== 16'h0 || pif.tx_pause_source_addr !== 48'h0
            || paused !== 1'b0 || xoff_cnt !== 16'h0 || xon_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b val=%h addr=%h paused=%b xoff=%0d xon=%0d, required all 0",
                     pif.tx_pause_req, pif.tx_pause_val, pif.tx_pause_source_addr, paused, xoff_cnt, xon_cnt);
        end
        enable = 1'b0; fifo_level = '0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            ack_pulse();
            tick();
        end
        n_checks++;
        if (xoff_cnt !== 16'h0 || xon_cnt !== 16'h0 || pif.tx_pause_req !== 1'b0 || paused !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: xoff=%0d xon=%0d req=%b paused=%b, required 0 0 0 0",
                     xoff_cnt, xon_cnt, pif.tx_pause_req, paused);
        end
    endtask

    initial begin
        test_reset();
        test_xoff_ramp();
        test_refresh(16'd2);
        test_xon();
        test_drain_before_ack();
        test_full_and_enable();
        test_reset_mid_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
